// File: rtl/snn_result_reporter_if.sv
`default_nettype none
// ============================================================================
// Module      : snn_result_reporter_if
// Description : Bundles the signals between the SNN core, the result
//               reporter and the UART transmitter.
//               master : the reporter. Core handshake (done, digit) and
//                        tx_rdy in; tx_start, tx_data, led, busy,
//                        fifo_count, overflow out.
//               slave  : the surrounding system (core, UART, status logic).
// Revision    : 1.0 - initial release
// ============================================================================
interface snn_result_reporter_if #(
   parameter int DIGIT_W    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int LED_W      = 8
);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

   logic                done;
   logic [DIGIT_W-1:0]  digit;
   logic                tx_rdy;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic [LED_W-1:0]    led;
   logic                busy;
   logic [c_cnt_w-1:0]  fifo_count;
   logic                overflow;

   modport master (
      input  done, digit, tx_rdy,
      output tx_start, tx_data, led, busy, fifo_count, overflow
   );

   modport slave (
      output done, digit, tx_rdy,
      input  tx_start, tx_data, led, busy, fifo_count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/snn_result_reporter.sv
`default_nettype none
// ============================================================================
// Module      : snn_result_reporter
// Description : Result back end for the SNN top level. Each done pulse
//               updates the LED register and queues the ASCII code of the
//               result ('0'.. or '?') in a small FIFO; an FSM drains the
//               FIFO to the UART transmitter, optionally followed by CR/LF.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - snn_result_reporter_if.master (done/digit in,
//                      tx_rdy in, tx_start/tx_data out, led, busy,
//                      fifo_count, overflow out); all outputs registered
// Revision    : 1.0 - initial release
// ============================================================================
module snn_result_reporter #(
   parameter int DIGIT_W     = 4,
   parameter int NUM_CLASSES = 10,
   parameter int FIFO_DEPTH  = 4,
   parameter int APPEND_CRLF = 1,
   parameter int LED_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   snn_result_reporter_if.master bus
);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHR   = 3'd1,
      S_CHR_W = 3'd2,
      S_CR    = 3'd3,
      S_CR_W  = 3'd4,
      S_LF    = 3'd5,
      S_LF_W  = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_state_nx;
   logic                 r_tx_start;
   logic                 w_tx_start_nx;
   logic [7:0]           r_tx_data;
   logic [7:0]           w_tx_data_nx;
   logic                 w_pop;

   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   r_wr_ptr;
   logic [c_ptr_w-1:0]   r_rd_ptr;
   logic [c_cnt_w-1:0]   r_count;
   logic [c_cnt_w-1:0]   w_count_nx;
   logic                 w_full;
   logic                 w_push;
   logic [7:0]           w_code;

   logic [LED_W-1:0]     r_led;
   logic                 r_busy;
   logic                 w_busy_nx;
   logic                 r_overflow;

   // Out-of-range results are reported as '?'.
   assign w_code = (int'(bus.digit) < NUM_CLASSES) ? (8'(bus.digit) + 8'h30) : 8'h3F;

   // A pop launched this cycle frees a slot, so a full FIFO still accepts
   // the push. Pop only happens when non-empty, so no empty read-through.
   assign w_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
   assign w_push     = bus.done && (!w_full || w_pop);
   assign w_count_nx = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

   // busy is registered, so it is derived from the next-state values.
   assign w_busy_nx = (w_count_nx != '0) || (w_state_nx != S_IDLE);

   // Next-state / output logic. In the wait states r_tx_start is still high
   // during the first cycle after a launch; that cycle ignores tx_rdy to
   // cover the transmitter's ready-deassert latency.
   always_comb begin
      w_state_nx    = r_state;
      w_tx_start_nx = 1'b0;
      w_tx_data_nx  = r_tx_data;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_count != '0) && bus.tx_rdy) begin
               w_pop         = 1'b1;
               w_tx_start_nx = 1'b1;
               w_tx_data_nx  = r_mem[r_rd_ptr];
               w_state_nx    = S_CHR_W;
            end
         end
         S_CHR_W: begin
            if (!r_tx_start && bus.tx_rdy)
               w_state_nx = (APPEND_CRLF != 0) ? S_CR : S_IDLE;
         end
         S_CR: begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = 8'h0D;
            w_state_nx    = S_CR_W;
         end
         S_CR_W: begin
            if (!r_tx_start && bus.tx_rdy)
               w_state_nx = S_LF;
         end
         S_LF: begin
            w_tx_start_nx = 1'b1;
            w_tx_data_nx  = 8'h0A;
            w_state_nx    = S_LF_W;
         end
         S_LF_W: begin
            if (!r_tx_start && bus.tx_rdy)
               w_state_nx = S_IDLE;
         end
         // The character launch is folded into IDLE, so CHR is never
         // entered; it and any illegal encoding recover to IDLE.
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= 8'h00;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_led      <= '0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_tx_start <= w_tx_start_nx;
         r_tx_data  <= w_tx_data_nx;
         r_count    <= w_count_nx;
         r_busy     <= w_busy_nx;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         if (bus.done)
            r_led <= LED_W'(bus.digit);
         if (bus.done && !w_push)
            r_overflow <= 1'b1;
      end
   end

   // Queue storage needs no reset: entries are only read behind r_count.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_code;
   end

   assign bus.tx_start   = r_tx_start;
   assign bus.tx_data    = r_tx_data;
   assign bus.led        = r_led;
   assign bus.busy       = r_busy;
   assign bus.fifo_count = r_count;
   assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: doc/snn_result_reporter.md
Name: snn_result_reporter

Overview:
Parametrised result-reporting back end for the SNN top level. Accepts classification results from the core's done/digit handshake and updates the LED register. Queues results in a small FIFO so back-to-back inferences are not lost. Drains the queue to the UART transmitter as ASCII characters, with an optional CR/LF terminator per result.

Parameters:
DIGIT_W, 4, width of the classification result from the core
NUM_CLASSES, 10, valid result range 0..NUM_CLASSES-1; other values are reported as '?'
FIFO_DEPTH, 4, result queue depth; power of two, >=2
APPEND_CRLF, 1, 1: send 0x0D,0x0A after each result character; 0: result character only
LED_W, 8, LED bus width; must be >= DIGIT_W

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-high reset
done  input  1  one-cycle pulse from the core: result valid
digit  input  DIGIT_W  classification result, sampled when done=1
tx_rdy  input  1  UART transmitter idle / ready for a byte
tx_start  output  1  one-cycle pulse launching a UART byte
tx_data  output  8  byte to transmit; valid while tx_start=1 and held until the next launch
led  output  LED_W  last result, zero-extended
busy  output  1  FIFO non-empty or FSM not in IDLE
fifo_count  output  $clog2(FIFO_DEPTH+1)  entries currently queued
overflow  output  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): led=0, tx_start=0, tx_data=0x00, busy=0, fifo_count=0, overflow=0. FIFO pointers cleared, FSM to IDLE. Reset asserted mid-byte aborts the sequence immediately; the queue is discarded and no further tx_start is issued.
- All outputs are registered.
- LED: on done=1, led <= {0, digit} on the next edge. This happens regardless of FIFO state.
- Push: on done=1 the ASCII code is computed and stored in the FIFO:
  - digit < NUM_CLASSES: code = digit + 0x30 (8-bit add)
  - otherwise: code = 0x3F
- FIFO full:
  - done with no pop in the same cycle: result dropped, overflow <= 1 (stays set until reset), fifo_count unchanged.
  - done with a pop in the same cycle: pop frees a slot and the push is accepted; count stays at FIFO_DEPTH.
- FIFO empty: push and pop in the same cycle cannot occur, because a pop requires non-empty at the cycle start. There is no read-through bypass; a pushed entry is poppable from the next cycle. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, CHR, CHR_W, CR, CR_W, LF, LF_W.
  - IDLE: if fifo_count != 0 and tx_rdy=1, pop the head, tx_data <= head, tx_start <= 1, go to CHR_W. Otherwise stay.
  - x_W states (CHR_W, CR_W, LF_W): tx_start <= 0. tx_rdy is ignored in the first cycle after the pulse, as the guard for the transmitter's ready deassert latency. From the second cycle on, advance when tx_rdy=1.
  - CHR_W advances to CR if APPEND_CRLF=1, else to IDLE.
  - CR: tx_data <= 0x0D, tx_start <= 1, go to CR_W. CR_W advances to LF.
  - LF: tx_data <= 0x0A, tx_start <= 1, go to LF_W. LF_W advances to IDLE.
- Timing: tx_start is never high on two consecutive cycles. Minimum gap between launches is 2 cycles plus the transmitter busy time. Latency from done (FIFO empty, FSM IDLE, tx_rdy=1) to tx_start is 2 cycles: push edge, then launch edge.
- done pulses arriving during a transmission only queue; they never alter the byte in flight.

Test Plan:
1. APPEND_CRLF=1: done with digit=7, tx model ready after 10 cycles busy -> led=0x07; tx_start pulses carry 0x37, 0x0D, 0x0A in order, one pulse each; busy falls after LF completes; fifo_count returns to 0.
2. digit=12 with NUM_CLASSES=10 -> led=0x0C; transmitted byte 0x3F, followed by CR/LF.
3. Six done pulses (digits 1..6) on consecutive cycles, FIFO_DEPTH=4, tx held busy -> fifo_count saturates at 4; overflow=1; led=0x06; after release, bytes 0x31..0x34 are sent (each with CR/LF), then nothing further.
4. APPEND_CRLF=0: digits 3, then 9 two cycles later -> exactly two tx_start pulses, carrying 0x33 then 0x39; no 0x0D/0x0A on the bus.
5. FIFO full and FSM launching a pop in the same cycle as done=5 -> push accepted; fifo_count stays 4; overflow stays 0; 0x35 is eventually sent.
6. rst asserted for 1 cycle while in CR_W with 2 entries queued -> all outputs reach reset values asynchronously; no further tx_start; a subsequent done=0 yields led=0x00 and transmission of 0x30, 0x0D, 0x0A.
